// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and counter sizing.
package serial_adder_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_SHIFT = ST_SHIFT,
    S_DONE  = ST_DONE
  } state_t;

  // Bit counter only has to reach WIDTH-1.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/full_adder_bit.sv
// One-bit combinational full adder; the single arithmetic stage of the serial adder.
module full_adder_bit (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Sum,
  output logic Carry
);

  assign Sum   = A ^ B ^ Cin;
  assign Carry = (A & B) | (A & Cin) | (B & Cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: feeds operands LSB-first through one full adder,
// recirculating the carry and shifting sum bits into the result register.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry
);

  localparam int              CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic             carry_q;
  logic [CW-1:0]    cnt;
  logic             s;
  logic             c;

  full_adder_bit u_fa (
    .A     (sh_a[0]),
    .B     (sh_b[0]),
    .Cin   (carry_q),
    .Sum   (s),
    .Carry (c)
  );

  assign busy = (state == S_SHIFT) || (state == S_DONE);
  assign done = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      sh_a    <= '0;
      sh_b    <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
      Sum     <= '0;
      Carry   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            sh_a    <= A;
            sh_b    <= B;
            carry_q <= Cin;
            cnt     <= '0;
            Sum     <= '0;
            state   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          // Result bits arrive LSB-first, so they enter at the MSB and walk down.
          Sum     <= {s, Sum[WIDTH-1:1]};
          sh_a    <= sh_a >> 1;
          sh_b    <= sh_b >> 1;
          carry_q <= c;
          if (cnt == LAST) begin
            Carry <= c;
            state <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and random checks of serial_adder_ctrl at WIDTH=8 and WIDTH=16 side by side.
module tb_serial_adder_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] A;
  logic [15:0] B;
  logic        Cin;

  logic        busy8, done8, carry8;
  logic [7:0]  sum8;
  logic        busy16, done16, carry16;
  logic [15:0] sum16;

  int n_err = 0;
  int n_chk = 0;
  int lat8, lat16, nd8, nd16, nb8, nb16;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start), .A(A[7:0]), .B(B[7:0]), .Cin(Cin),
    .busy(busy8), .done(done8), .Sum(sum8), .Carry(carry8)
  );

  serial_adder_ctrl #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .Cin(Cin),
    .busy(busy16), .done(done16), .Sum(sum16), .Carry(carry16)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Start both DUTs together, optionally pulse start again at cycle mid with other operands.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                        input int mid, input logic [15:0] ma, input logic [15:0] mb);
    lat8 = 0; lat16 = 0; nd8 = 0; nd16 = 0; nb8 = 0; nb16 = 0;
    @(negedge clk);
    A = a; B = b; Cin = cin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    A = ~a; B = ~b; Cin = ~cin;
    for (int k = 1; k <= 20; k++) begin
      if (done8)  begin nd8++;  if (lat8 == 0)  lat8 = k;  end
      if (done16) begin nd16++; if (lat16 == 0) lat16 = k; end
      if (busy8)  nb8++;
      if (busy16) nb16++;
      if (k == mid) begin start = 1'b1; A = ma; B = mb; end
      else start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic check_res(input string tag, input logic [8:0] e8, input logic [16:0] e16);
    chk({tag, "_r8"},  {carry8, sum8},   e8);
    chk({tag, "_r16"}, {carry16, sum16}, e16);
    chk({tag, "_lat8"},  lat8,  9);
    chk({tag, "_lat16"}, lat16, 17);
    chk({tag, "_nd8"},  nd8,  1);
    chk({tag, "_nd16"}, nd16, 1);
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic        rc;
    logic [8:0]  e8;
    logic [16:0] e16;
    int          nd;
    logic        b_k10, b_k11;

    rst = 1'b1; start = 1'b0; A = '0; B = '0; Cin = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy8", busy8, 0);
    chk("rst_done8", done8, 0);
    chk("rst_res8", {carry8, sum8}, 0);
    chk("rst_busy16", busy16, 0);
    chk("rst_res16", {carry16, sum16}, 0);
    rst = 1'b0;

    run_op(16'h0005, 16'h0003, 1'b0, 0, 16'h0, 16'h0);
    check_res("basic", 9'h008, 17'h00008);
    chk("basic_busy8", nb8, 9);
    chk("basic_busy16", nb16, 17);

    run_op(16'hFFFF, 16'h0001, 1'b0, 0, 16'h0, 16'h0);
    check_res("chain", 9'h100, 17'h10000);

    run_op(16'hFFFF, 16'hFFFF, 1'b1, 0, 16'h0, 16'h0);
    check_res("max", 9'h1FF, 17'h1FFFF);

    run_op(16'h0000, 16'h0000, 1'b1, 0, 16'h0, 16'h0);
    check_res("cin_only", 9'h001, 17'h00001);

    run_op(16'h0010, 16'h0020, 1'b0, 3, 16'h00AA, 16'h0055);
    check_res("ign_start", 9'h030, 17'h00030);

    // Hold start high: the 8-bit unit restarts only once it is back in IDLE.
    @(negedge clk);
    A = 16'h0021; B = 16'h0012; Cin = 1'b0; start = 1'b1;
    nd = 0; b_k10 = 1'b1; b_k11 = 1'b0;
    @(negedge clk);
    for (int k = 1; k <= 11; k++) begin
      if (done8 && k <= 10) nd++;
      if (k == 10) b_k10 = busy8;
      if (k == 11) b_k11 = busy8;
      @(negedge clk);
    end
    start = 1'b0;
    repeat (20) @(negedge clk);
    chk("hold_nd8", nd, 1);
    chk("hold_idle8", b_k10, 0);
    chk("hold_restart8", b_k11, 1);
    chk("hold_r8", {carry8, sum8}, 9'h033);
    chk("hold_r16", {carry16, sum16}, 17'h00033);

    // Reset during the fourth shift edge discards the partial result.
    @(negedge clk);
    A = 16'h007F; B = 16'h0001; Cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_res8", {carry8, sum8}, 0);
    chk("mid_rst_busy8", busy8, 0);
    chk("mid_rst_done8", done8, 0);
    chk("mid_rst_res16", {carry16, sum16}, 0);
    chk("mid_rst_busy16", busy16, 0);
    nd = 0;
    repeat (20) begin
      if (done8 || done16) nd++;
      @(negedge clk);
    end
    chk("mid_rst_nodone", nd, 0);
    run_op(16'h0002, 16'h0002, 1'b0, 0, 16'h0, 16'h0);
    check_res("after_rst", 9'h004, 17'h00004);

    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom_range(0, 1));
      e8  = {1'b0, ra[7:0]} + {1'b0, rb[7:0]} + {8'd0, rc};
      e16 = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
      run_op(ra, rb, rc, 0, 16'h0, 16'h0);
      chk("rnd_r8", {carry8, sum8}, e8);
      chk("rnd_r16", {carry16, sum16}, e16);
      chk("rnd_lat8", lat8, 9);
      chk("rnd_lat16", lat16, 17);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial N-bit adder built around a single one-bit full adder stage. It loads two WIDTH-bit operands on a start request and feeds them LSB-first, one bit per cycle, into the full adder. It registers the carry-out back into carry-in and shifts each sum bit into a result register. It signals completion with a one-cycle done pulse and holds the result until the next accepted start. Intended as the sequential wrapper that drives and consumes the team's one-bit full adder in area-constrained datapaths.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..64.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request to begin an addition; sampled only in IDLE
A  input  WIDTH  operand A; captured on accepted start
B  input  WIDTH  operand B; captured on accepted start
Cin  input  1  initial carry-in; captured on accepted start
busy  output  1  high while in SHIFT or DONE state
done  output  1  one-cycle pulse when Sum/Carry become valid
Sum  output  WIDTH  result bits; held stable from done until the next accepted start
Carry  output  1  final carry-out; held with Sum

Behaviour:
- Reset is synchronous and active-high: rst sampled high on a rising clk edge forces the following values regardless of state or start.
  - state=IDLE, Sum=0, Carry=0, done=0, busy=0.
  - Bit counter and both operand shift registers are cleared.
- States: IDLE, SHIFT, DONE. Encoding is 2-bit, with constants held in the package.
- IDLE:
  - If start=1, load shA<=A, shB<=B, carry_q<=Cin, cnt<=0, and clear the Sum register. Go to SHIFT.
  - If start=0, stay in IDLE.
- SHIFT (one bit per cycle):
  - Full adder inputs are shA[0], shB[0], carry_q. Full adder outputs are s and c.
  - Sum<={s, Sum[WIDTH-1:1]} (LSB-first result enters at the MSB and shifts right).
  - shA and shB shift right by 1, with zero fill.
  - carry_q<=c and cnt<=cnt+1.
  - When cnt==WIDTH-1, that cycle's bit is the last one: Carry<=c, then go to DONE.
- DONE: done=1 for exactly this one cycle. Go to IDLE unconditionally. start is ignored in DONE.
- Latency: start accepted at edge t. done=1 during the cycle after edge t+WIDTH (WIDTH shift edges). Next start can be accepted at edge t+WIDTH+2.
- Outputs are registered. done and busy are decoded from state only.
- start=1 during SHIFT or DONE is ignored; no queuing.
- A, B and Cin may change freely after the accepted start edge without affecting the result.
- Arithmetic: {Carry, Sum} == A + B + Cin, computed modulo 2^(WIDTH+1); no overflow flag.
- Reset mid-operation: the partial result is discarded and done is not pulsed. The next start after reset deasserts behaves normally.
- Counter width is $clog2(WIDTH). It never wraps past WIDTH-1.

Decomposition:
- Package serial_adder_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2;
  - a function computing the counter width from WIDTH.
- One natural sub-module: full_adder_bit (ports A, B, Cin, Sum, Carry; purely combinational), instantiated once.
- The FSM, shift registers, carry flop and counter stay in serial_adder_ctrl.

Test Plan:
- Basic add: WIDTH=8, A=8'h05, B=8'h03, Cin=0, start for 1 cycle -> done pulses 9 cycles after start edge, Sum=8'h08, Carry=0, busy high for 9 cycles.
- Full carry chain: A=8'hFF, B=8'h01, Cin=0 -> Sum=8'h00, Carry=1.
- Maximum with carry-in: A=8'hFF, B=8'hFF, Cin=1 -> Sum=8'hFF, Carry=1. Also A=0, B=0, Cin=1 -> Sum=8'h01, Carry=0.
- Ignored start: start A=8'h10, B=8'h20; at cycle 3 pulse start with A=8'hAA, B=8'h55 -> result Sum=8'h30, Carry=0, exactly one done pulse. start held high through DONE -> next operation begins only from IDLE.
- Reset mid-operation: start A=8'h7F, B=8'h01; assert rst at shift cycle 4 for 1 cycle -> next edge Sum=0, Carry=0, busy=0, no done pulse. Subsequent start A=8'h02, B=8'h02 -> Sum=8'h04.
- Randomized check, WIDTH=8 and WIDTH=16: 1000 random A/B/Cin sets -> every result equals the reference sum {Carry, Sum}=A+B+Cin, with done latency always WIDTH+1 cycles.
